// File: rtl/four_to_one_mux.sv
// Purpose: registered 4:1 multiplexer; {s_0,s_1} picks one of p_0..p_3 onto OUT.
// Latency: exactly one core clock from any input to OUT; no combinational input-to-output path.
// Backpressure: none; there is no enable or handshake, so OUT reloads on every non-reset edge.
module four_to_one_mux #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] p_0,
    input  logic [WIDTH-1:0] p_1,
    input  logic [WIDTH-1:0] p_2,
    input  logic [WIDTH-1:0] p_3,
    input  logic             s_0,
    input  logic             s_1,
    output logic [WIDTH-1:0] OUT
);

    // s_0 is the high bit of the select index and s_1 the low bit.
    logic [1:0]       sel;
    logic [WIDTH-1:0] mux_dat;

    assign sel = {s_0, s_1};

    // Pick the addressed port; p_3 is also the default arm so the mux is complete.
    always_comb begin
        mux_dat = p_3;
        case (sel)
            2'b00:   mux_dat = p_0;
            2'b01:   mux_dat = p_1;
            2'b10:   mux_dat = p_2;
            default: mux_dat = p_3;
        endcase
    end

    // Register the selection; a low rst_n at the edge clears OUT, whatever the inputs are doing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            OUT <= '0;
        end else begin
            OUT <= mux_dat;
        end
    end

endmodule

// File: tb/tb_four_to_one_mux.sv
module tb_four_to_one_mux;

    logic       clk;
    logic       rst_n;
    logic [7:0] p0, p1, p2, p3;
    logic       s0, s1;
    logic       out1;
    logic [7:0] out8;

    int errors = 0;
    int checks = 0;

    // Two builds share one stimulus: the default 1-bit width, and an 8-bit build.
    four_to_one_mux #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .p_0(p0[0]), .p_1(p1[0]), .p_2(p2[0]), .p_3(p3[0]),
        .s_0(s0), .s_1(s1), .OUT(out1)
    );

    four_to_one_mux #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .p_0(p0), .p_1(p1), .p_2(p2), .p_3(p3),
        .s_0(s0), .s_1(s1), .OUT(out8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: at each rising edge, the output becomes zero under reset, otherwise the
    // port numbered (2*s_0 + s_1) as seen at that edge.
    logic [7:0] m_out;
    bit         m_vld = 1'b0;
    always @(posedge clk) begin
        logic [7:0] ports [4];
        int         idx;
        ports[0] = p0;
        ports[1] = p1;
        ports[2] = p2;
        ports[3] = p3;
        idx      = 2 * int'(s0) + int'(s1);
        m_out    = rst_n ? ports[idx] : 8'h00;
        m_vld    = 1'b1;
    end

    // Every falling edge after the first rising edge, compare both builds with the reference.
    always @(negedge clk) begin
        if (m_vld) begin
            checks++;
            if (out8 !== m_out) begin
                errors++;
                $display("FAIL model_w8 t=%0t got=%h want=%h", $time, out8, m_out);
            end
            checks++;
            if (out1 !== m_out[0]) begin
                errors++;
                $display("FAIL model_w1 t=%0t got=%b want=%b", $time, out1, m_out[0]);
            end
        end
    end

    task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one vector, take one edge, then check both builds against hand-computed values.
    task automatic vec(input string name, input logic a0, input logic a1,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3,
                       input logic e1, input logic [7:0] e8);
        s0 = a0; s1 = a1;
        p0 = d0; p1 = d1; p2 = d2; p3 = d3;
        tick();
        lit({name, "_w1"}, {7'd0, out1}, {7'd0, e1});
        lit({name, "_w8"}, out8, e8);
    endtask

    initial begin
        rst_n = 1'b0;
        s0 = 1'b0; s1 = 1'b0;
        p0 = 8'h01; p1 = 8'h01; p2 = 8'h01; p3 = 8'h01;

        // Reset held for two edges with every port at 1.
        tick();
        tick();
        lit("reset_w1", {7'd0, out1}, 8'h00);
        lit("reset_w8", out8, 8'h00);
        rst_n = 1'b1;
        tick();
        lit("release_w1", {7'd0, out1}, 8'h01);
        lit("release_w8", out8, 8'h01);

        // Each port selected in turn; the selected port differs from all the others.
        vec("sel0_lo", 1'b0, 1'b0, 8'h00, 8'h01, 8'h01, 8'h01, 1'b0, 8'h00);
        vec("sel0_hi", 1'b0, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 8'h01);
        vec("sel1_lo", 1'b0, 1'b1, 8'h01, 8'h00, 8'h01, 8'h01, 1'b0, 8'h00);
        vec("sel1_hi", 1'b0, 1'b1, 8'h00, 8'h01, 8'h00, 8'h00, 1'b1, 8'h01);
        vec("sel2_lo", 1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 8'h01, 1'b0, 8'h00);
        vec("sel2_hi", 1'b1, 1'b0, 8'h00, 8'h00, 8'h01, 8'h00, 1'b1, 8'h01);
        vec("sel3_lo", 1'b1, 1'b1, 8'h01, 8'h01, 8'h01, 8'h00, 1'b0, 8'h00);
        vec("sel3_hi", 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 8'h01);

        // A select change between edges must not reach OUT before the next edge.
        s0 = 1'b0; s1 = 1'b0;
        #2;
        lit("midcyc_hold_w8", out8, 8'h01);
        lit("midcyc_hold_w1", {7'd0, out1}, 8'h01);
        tick();
        lit("midcyc_load_w8", out8, 8'h00);

        // Select and data change together: the new data on the new port appears.
        vec("both_chg", 1'b1, 1'b0, 8'h00, 8'h00, 8'h3C, 8'h00, 1'b0, 8'h3C);

        // Reset dropped between edges leaves OUT alone until the edge, then clears it.
        rst_n = 1'b0;
        #3;
        lit("rst_mid_hold", out8, 8'h3C);
        tick();
        lit("rst_mid_clr", out8, 8'h00);
        rst_n = 1'b1;
        tick();
        lit("rst_mid_reload", out8, 8'h3C);

        // Wide data across all four selects.
        vec("w8_sel0", 1'b0, 1'b0, 8'hA5, 8'h5A, 8'hFF, 8'h00, 1'b1, 8'hA5);
        vec("w8_sel1", 1'b0, 1'b1, 8'hA5, 8'h5A, 8'hFF, 8'h00, 1'b0, 8'h5A);
        vec("w8_sel2", 1'b1, 1'b0, 8'hA5, 8'h5A, 8'hFF, 8'h00, 1'b1, 8'hFF);
        vec("w8_sel3", 1'b1, 1'b1, 8'hA5, 8'h5A, 8'hFF, 8'h00, 1'b0, 8'h00);

        // Unselected ports toggling must not disturb OUT.
        vec("unsel_a", 1'b0, 1'b1, 8'hFF, 8'h96, 8'hFF, 8'hFF, 1'b0, 8'h96);
        vec("unsel_b", 1'b0, 1'b1, 8'h00, 8'h96, 8'h00, 8'h00, 1'b0, 8'h96);

        // Reset wins over live data.
        rst_n = 1'b0;
        vec("rst_over", 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'h00);
        rst_n = 1'b1;
        vec("final", 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hC3, 1'b1, 8'hC3);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/four_to_one_mux.md
Name: four_to_one_mux

Overview:
- Registered 4:1 multiplexer. It selects one of four data inputs (p_0..p_3) using a 2-bit select formed from s_0 and s_1, and drives the selected value on OUT.
- General-purpose datapath leaf cell, used wherever a one-of-four choice is needed ahead of downstream logic.
- Output is registered on the single clock and cleared by a synchronous active-low reset.

Parameters:
- WIDTH, 1, bit width of each data input p_0..p_3 and of OUT.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising clk edge.
- p_0  input  WIDTH  data input, selected when {s_0,s_1} = 2'b00.
- p_1  input  WIDTH  data input, selected when {s_0,s_1} = 2'b01.
- p_2  input  WIDTH  data input, selected when {s_0,s_1} = 2'b10.
- p_3  input  WIDTH  data input, selected when {s_0,s_1} = 2'b11.
- s_0  input  1  select MSB.
- s_1  input  1  select LSB.
- OUT  output  WIDTH  registered selected data.

Behaviour:
- Select index sel = {s_0, s_1}; s_0 is the MSB.
  - sel 0 -> p_0; sel 1 -> p_1; sel 2 -> p_2; sel 3 -> p_3.
- On each rising clk edge with rst_n = 1: OUT <= p_sel, using the p_*/s_* values sampled at that edge.
- Latency is exactly 1 clock from inputs to OUT. No combinational path exists from any input to OUT.
- Reset: on a rising clk edge with rst_n = 0, OUT <= all zeros. Reset overrides the data path regardless of p_*/s_* values.
- Reset is not asynchronous: asserting rst_n low between edges leaves OUT unchanged until the next rising edge.
- Reset mid-operation: the next edge after rst_n goes low clears OUT. The first edge with rst_n = 1 again loads the currently selected input.
- Simultaneous change of select and data before an edge: OUT takes the new data of the newly selected port at that edge. No glitch is visible on OUT.
- Unselected inputs have no effect on OUT.
- X/Z on select: no defined requirement beyond simulation propagation. Implementation uses a full case with p_3 as the default branch, so no latch is inferred.
- No enable and no handshake: OUT updates every non-reset cycle.
- WIDTH applies uniformly to all data ports. Selection is bitwise-identical across all bits, with no width conversion.

Test Plan:
- Reset: hold rst_n = 0 for 2 edges with p_0..p_3 = 1,1,1,1 and sel = 0 -> OUT = 0. Release rst_n; next edge -> OUT = 1.
- Port 0, sel {s_0,s_1} = 00: p = 0,1,1,1 -> OUT = 0 one edge later; then p = 1,0,0,0 -> OUT = 1.
- Port 1, sel = 01: p = 1,0,1,1 -> OUT = 0; then p = 0,1,0,0 -> OUT = 1. This confirms s_1 is the LSB.
- Port 2, sel = 10: p = 1,1,0,1 -> OUT = 0; then p = 0,0,1,0 -> OUT = 1. This confirms s_0 is the MSB.
- Port 3, sel = 11: p = 1,1,1,0 -> OUT = 0; then p = 0,0,0,1 -> OUT = 1.
- Timing/reset edge cases:
  - Change sel mid-cycle -> OUT holds until the next edge.
  - Drop rst_n between edges -> OUT unchanged until the edge, then 0.
  - With WIDTH = 8, p = 8'hA5, 8'h5A, 8'hFF, 8'h00 over sel 0..3 -> OUT = A5, 5A, FF, 00 on successive edges.
